// File: rtl/ace_rd_arbiter.sv
// ace_rd_arbiter: shares the core's single ACE master port between IFU and LSU.
// The AR/R channels are arbitrated one read burst at a time. Write and snoop
// channels belong to the LSU alone, so the IFU copies of those are tied off.
module ace_rd_arbiter #(
    parameter int ARB_MODE     = 0,
    parameter int STARVE_LIMIT = 4,
    parameter int ADDR_W       = 32,
    parameter int ID_W         = 4,
    parameter int DATA_W       = 64,
    parameter int AW_PLD_W     = 64,
    parameter int W_PLD_W      = 73,
    parameter int B_PLD_W      = 6,
    parameter int AC_PLD_W     = 40,
    parameter int CR_PLD_W     = 5,
    parameter int CD_PLD_W     = 65
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ifu_arvalid,
    output logic                ifu_arready,
    input  logic [ADDR_W-1:0]   ifu_araddr,
    input  logic [ID_W-1:0]     ifu_arid,
    input  logic [7:0]          ifu_arlen,
    input  logic [2:0]          ifu_arsize,
    input  logic [1:0]          ifu_arburst,
    input  logic [3:0]          ifu_arsnoop,
    input  logic [1:0]          ifu_ardomain,
    output logic                ifu_rvalid,
    input  logic                ifu_rready,
    output logic [DATA_W-1:0]   ifu_rdata,
    output logic [ID_W-1:0]     ifu_rid,
    output logic [3:0]          ifu_rresp,
    output logic                ifu_rlast,
    input  logic                ifu_awvalid,
    output logic                ifu_awready,
    input  logic                ifu_wvalid,
    output logic                ifu_wready,
    output logic                ifu_bvalid,
    input  logic                ifu_bready,
    output logic                ifu_acvalid,
    input  logic                ifu_acready,
    input  logic                ifu_crvalid,
    output logic                ifu_crready,
    input  logic                ifu_cdvalid,
    output logic                ifu_cdready,
    input  logic                lsu_arvalid,
    output logic                lsu_arready,
    input  logic [ADDR_W-1:0]   lsu_araddr,
    input  logic [ID_W-1:0]     lsu_arid,
    input  logic [7:0]          lsu_arlen,
    input  logic [2:0]          lsu_arsize,
    input  logic [1:0]          lsu_arburst,
    input  logic [3:0]          lsu_arsnoop,
    input  logic [1:0]          lsu_ardomain,
    output logic                lsu_rvalid,
    input  logic                lsu_rready,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic [ID_W-1:0]     lsu_rid,
    output logic [3:0]          lsu_rresp,
    output logic                lsu_rlast,
    input  logic                lsu_awvalid,
    output logic                lsu_awready,
    input  logic [AW_PLD_W-1:0] lsu_aw_pld,
    input  logic                lsu_wvalid,
    output logic                lsu_wready,
    input  logic [W_PLD_W-1:0]  lsu_w_pld,
    output logic                lsu_bvalid,
    input  logic                lsu_bready,
    output logic [B_PLD_W-1:0]  lsu_b_pld,
    output logic                lsu_acvalid,
    input  logic                lsu_acready,
    output logic [AC_PLD_W-1:0] lsu_ac_pld,
    input  logic                lsu_crvalid,
    output logic                lsu_crready,
    input  logic [CR_PLD_W-1:0] lsu_cr_pld,
    input  logic                lsu_cdvalid,
    output logic                lsu_cdready,
    input  logic [CD_PLD_W-1:0] lsu_cd_pld,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic [ID_W-1:0]     m_arid,
    output logic [7:0]          m_arlen,
    output logic [2:0]          m_arsize,
    output logic [1:0]          m_arburst,
    output logic [3:0]          m_arsnoop,
    output logic [1:0]          m_ardomain,
    input  logic                m_rvalid,
    output logic                m_rready,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [ID_W-1:0]     m_rid,
    input  logic [3:0]          m_rresp,
    input  logic                m_rlast,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [AW_PLD_W-1:0] m_aw_pld,
    output logic                m_wvalid,
    input  logic                m_wready,
    output logic [W_PLD_W-1:0]  m_w_pld,
    input  logic                m_bvalid,
    output logic                m_bready,
    input  logic [B_PLD_W-1:0]  m_b_pld,
    input  logic                m_acvalid,
    output logic                m_acready,
    input  logic [AC_PLD_W-1:0] m_ac_pld,
    output logic                m_crvalid,
    input  logic                m_crready,
    output logic [CR_PLD_W-1:0] m_cr_pld,
    output logic                m_cdvalid,
    input  logic                m_cdready,
    output logic [CD_PLD_W-1:0] m_cd_pld,
    output logic                arb_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_e;

    localparam logic       OWN_IFU = 1'b0;
    localparam logic       OWN_LSU = 1'b1;
    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic [3:0] starve_cnt_q, starve_cnt_d;
    logic       arb_err_q, arb_err_d;
    logic       grant_lsu;
    logic       unused_ifu_tieoff;

    // Arbiter state; after reset the LSU counts as last owner so the IFU wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            owner_q      <= OWN_LSU;
            starve_cnt_q <= '0;
            arb_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            arb_err_q    <= arb_err_d;
        end
    end

    // Winner selection in IDLE, handshake-driven progress through ADDR and DATA
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        arb_err_d    = arb_err_q;
        if (ARB_MODE == 1) begin
            grant_lsu = lsu_arvalid && !(ifu_arvalid && (starve_cnt_q == LIMIT));
        end else begin
            grant_lsu = lsu_arvalid && !(ifu_arvalid && (owner_q == OWN_LSU));
        end
        if (m_rvalid && (state_q != DATA)) begin
            arb_err_d = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (ifu_arvalid || lsu_arvalid) begin
                    state_d = ADDR;
                    owner_d = grant_lsu ? OWN_LSU : OWN_IFU;
                    if (ARB_MODE == 1) begin
                        if (grant_lsu && ifu_arvalid) begin
                            starve_cnt_d = (starve_cnt_q == LIMIT) ? LIMIT : starve_cnt_q + 4'd1;
                        end else begin
                            starve_cnt_d = '0;
                        end
                    end
                end
            end
            ADDR: begin
                if (m_arvalid && m_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (m_rvalid && m_rready && m_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Steer handshakes to the owner only; payloads are muxed unconditionally and qualified by valid
    always_comb begin
        m_arvalid   = 1'b0;
        ifu_arready = 1'b0;
        lsu_arready = 1'b0;
        m_rready    = 1'b0;
        ifu_rvalid  = 1'b0;
        lsu_rvalid  = 1'b0;
        m_araddr    = owner_q ? lsu_araddr   : ifu_araddr;
        m_arid      = owner_q ? lsu_arid     : ifu_arid;
        m_arlen     = owner_q ? lsu_arlen    : ifu_arlen;
        m_arsize    = owner_q ? lsu_arsize   : ifu_arsize;
        m_arburst   = owner_q ? lsu_arburst  : ifu_arburst;
        m_arsnoop   = owner_q ? lsu_arsnoop  : ifu_arsnoop;
        m_ardomain  = owner_q ? lsu_ardomain : ifu_ardomain;
        case (state_q)
            ADDR: begin
                m_arvalid   = owner_q ? lsu_arvalid : ifu_arvalid;
                ifu_arready = (owner_q == OWN_IFU) && m_arready;
                lsu_arready = (owner_q == OWN_LSU) && m_arready;
            end
            DATA: begin
                m_rready   = owner_q ? lsu_rready : ifu_rready;
                ifu_rvalid = (owner_q == OWN_IFU) && m_rvalid;
                lsu_rvalid = (owner_q == OWN_LSU) && m_rvalid;
            end
            default: ;
        endcase
    end

    assign ifu_rdata = m_rdata;
    assign ifu_rid   = m_rid;
    assign ifu_rresp = m_rresp;
    assign ifu_rlast = m_rlast;
    assign lsu_rdata = m_rdata;
    assign lsu_rid   = m_rid;
    assign lsu_rresp = m_rresp;
    assign lsu_rlast = m_rlast;

    assign m_awvalid   = lsu_awvalid;
    assign lsu_awready = m_awready;
    assign m_aw_pld    = lsu_aw_pld;
    assign m_wvalid    = lsu_wvalid;
    assign lsu_wready  = m_wready;
    assign m_w_pld     = lsu_w_pld;
    assign lsu_bvalid  = m_bvalid;
    assign m_bready    = lsu_bready;
    assign lsu_b_pld   = m_b_pld;
    assign lsu_acvalid = m_acvalid;
    assign m_acready   = lsu_acready;
    assign lsu_ac_pld  = m_ac_pld;
    assign m_crvalid   = lsu_crvalid;
    assign lsu_crready = m_crready;
    assign m_cr_pld    = lsu_cr_pld;
    assign m_cdvalid   = lsu_cdvalid;
    assign lsu_cdready = m_cdready;
    assign m_cd_pld    = lsu_cd_pld;

    assign ifu_awready = 1'b0;
    assign ifu_wready  = 1'b0;
    assign ifu_bvalid  = 1'b0;
    assign ifu_acvalid = 1'b0;
    assign ifu_crready = 1'b0;
    assign ifu_cdready = 1'b0;

    // The IFU never writes or answers snoops, so its requests on those channels go nowhere
    assign unused_ifu_tieoff = ^{ifu_awvalid, ifu_wvalid, ifu_bready, ifu_acready, ifu_crvalid, ifu_cdvalid};

    assign arb_err = arb_err_q;

endmodule

// File: tb/tb_ace_rd_arbiter.sv
// tb_ace_rd_arbiter: directed bench for the IFU/LSU read arbiter.
// Instance 0 runs round-robin, instance 1 runs LSU priority with a starvation limit of 2.
module tb_ace_rd_arbiter;

    localparam int AW = 16;
    localparam int IW = 4;
    localparam int DW = 16;
    localparam int PW = 8;
    localparam logic [IW-1:0] IFU_ID   = 4'h1;
    localparam logic [IW-1:0] LSU_ID   = 4'h2;
    localparam logic [AW-1:0] IFU_ADDR = 16'h1000;
    localparam logic [AW-1:0] LSU_ADDR = 16'h8040;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic dut_sel = 1'b0;
    int   checks = 0;
    int   failures = 0;
    logic [IW-1:0] exp_q [$];

    logic          ifu_arvalid, ifu_rready, lsu_arvalid, lsu_rready;
    logic [AW-1:0] ifu_araddr, lsu_araddr;
    logic [IW-1:0] ifu_arid, lsu_arid;
    logic [7:0]    ifu_arlen, lsu_arlen;
    logic          m_arready, m_rvalid, m_rlast;
    logic [DW-1:0] m_rdata;
    logic [IW-1:0] m_rid;
    logic          lsu_awvalid, lsu_wvalid, lsu_bready, lsu_acready, lsu_crvalid, lsu_cdvalid;
    logic [PW-1:0] lsu_aw_pld, lsu_w_pld, lsu_cr_pld, lsu_cd_pld, m_b_pld, m_ac_pld;
    logic          m_awready, m_wready, m_bvalid, m_acvalid, m_crready, m_cdready;

    logic [1:0]    o_ifu_arready, o_ifu_rvalid, o_ifu_rlast, o_lsu_arready, o_lsu_rvalid, o_lsu_rlast;
    logic [1:0]    o_ifu_awready, o_ifu_wready, o_ifu_bvalid, o_ifu_acvalid, o_ifu_crready, o_ifu_cdready;
    logic [1:0]    o_lsu_awready, o_lsu_wready, o_lsu_bvalid, o_lsu_acvalid, o_lsu_crready, o_lsu_cdready;
    logic [1:0]    o_m_arvalid, o_m_rready, o_m_awvalid, o_m_wvalid, o_m_bready, o_m_acready;
    logic [1:0]    o_m_crvalid, o_m_cdvalid, o_arb_err;
    logic [DW-1:0] o_ifu_rdata [2];
    logic [DW-1:0] o_lsu_rdata [2];
    logic [IW-1:0] o_ifu_rid [2];
    logic [IW-1:0] o_lsu_rid [2];
    logic [3:0]    o_ifu_rresp [2];
    logic [3:0]    o_lsu_rresp [2];
    logic [PW-1:0] o_lsu_b_pld [2];
    logic [PW-1:0] o_lsu_ac_pld [2];
    logic [AW-1:0] o_m_araddr [2];
    logic [IW-1:0] o_m_arid [2];
    logic [7:0]    o_m_arlen [2];
    logic [2:0]    o_m_arsize [2];
    logic [1:0]    o_m_arburst [2];
    logic [3:0]    o_m_arsnoop [2];
    logic [1:0]    o_m_ardomain [2];
    logic [PW-1:0] o_m_aw_pld [2];
    logic [PW-1:0] o_m_w_pld [2];
    logic [PW-1:0] o_m_cr_pld [2];
    logic [PW-1:0] o_m_cd_pld [2];

    wire          s_ifu_arready = o_ifu_arready[dut_sel];
    wire          s_lsu_arready = o_lsu_arready[dut_sel];
    wire          s_ifu_rvalid  = o_ifu_rvalid[dut_sel];
    wire          s_lsu_rvalid  = o_lsu_rvalid[dut_sel];
    wire [DW-1:0] s_ifu_rdata   = o_ifu_rdata[dut_sel];
    wire [DW-1:0] s_lsu_rdata   = o_lsu_rdata[dut_sel];
    wire          s_m_arvalid   = o_m_arvalid[dut_sel];
    wire [AW-1:0] s_m_araddr    = o_m_araddr[dut_sel];
    wire [IW-1:0] s_m_arid      = o_m_arid[dut_sel];
    wire [7:0]    s_m_arlen     = o_m_arlen[dut_sel];
    wire          s_m_rready    = o_m_rready[dut_sel];
    wire          s_arb_err     = o_arb_err[dut_sel];

    always #5 clk = ~clk;

    ace_rd_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(4), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW),
        .AW_PLD_W(PW), .W_PLD_W(PW), .B_PLD_W(PW), .AC_PLD_W(PW), .CR_PLD_W(PW), .CD_PLD_W(PW)) u_dut0 (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(o_ifu_arready[0]), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
        .ifu_arlen(ifu_arlen), .ifu_arsize(3'd1), .ifu_arburst(2'b01), .ifu_arsnoop(4'd0), .ifu_ardomain(2'd0),
        .ifu_rvalid(o_ifu_rvalid[0]), .ifu_rready(ifu_rready), .ifu_rdata(o_ifu_rdata[0]), .ifu_rid(o_ifu_rid[0]),
        .ifu_rresp(o_ifu_rresp[0]), .ifu_rlast(o_ifu_rlast[0]),
        .ifu_awvalid(1'b0), .ifu_awready(o_ifu_awready[0]), .ifu_wvalid(1'b0), .ifu_wready(o_ifu_wready[0]),
        .ifu_bvalid(o_ifu_bvalid[0]), .ifu_bready(1'b0), .ifu_acvalid(o_ifu_acvalid[0]), .ifu_acready(1'b0),
        .ifu_crvalid(1'b0), .ifu_crready(o_ifu_crready[0]), .ifu_cdvalid(1'b0), .ifu_cdready(o_ifu_cdready[0]),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(o_lsu_arready[0]), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
        .lsu_arlen(lsu_arlen), .lsu_arsize(3'd1), .lsu_arburst(2'b01), .lsu_arsnoop(4'd0), .lsu_ardomain(2'd1),
        .lsu_rvalid(o_lsu_rvalid[0]), .lsu_rready(lsu_rready), .lsu_rdata(o_lsu_rdata[0]), .lsu_rid(o_lsu_rid[0]),
        .lsu_rresp(o_lsu_rresp[0]), .lsu_rlast(o_lsu_rlast[0]),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(o_lsu_awready[0]), .lsu_aw_pld(lsu_aw_pld),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(o_lsu_wready[0]), .lsu_w_pld(lsu_w_pld),
        .lsu_bvalid(o_lsu_bvalid[0]), .lsu_bready(lsu_bready), .lsu_b_pld(o_lsu_b_pld[0]),
        .lsu_acvalid(o_lsu_acvalid[0]), .lsu_acready(lsu_acready), .lsu_ac_pld(o_lsu_ac_pld[0]),
        .lsu_crvalid(lsu_crvalid), .lsu_crready(o_lsu_crready[0]), .lsu_cr_pld(lsu_cr_pld),
        .lsu_cdvalid(lsu_cdvalid), .lsu_cdready(o_lsu_cdready[0]), .lsu_cd_pld(lsu_cd_pld),
        .m_arvalid(o_m_arvalid[0]), .m_arready(m_arready), .m_araddr(o_m_araddr[0]), .m_arid(o_m_arid[0]),
        .m_arlen(o_m_arlen[0]), .m_arsize(o_m_arsize[0]), .m_arburst(o_m_arburst[0]), .m_arsnoop(o_m_arsnoop[0]),
        .m_ardomain(o_m_ardomain[0]), .m_rvalid(m_rvalid), .m_rready(o_m_rready[0]), .m_rdata(m_rdata),
        .m_rid(m_rid), .m_rresp(4'd0), .m_rlast(m_rlast),
        .m_awvalid(o_m_awvalid[0]), .m_awready(m_awready), .m_aw_pld(o_m_aw_pld[0]),
        .m_wvalid(o_m_wvalid[0]), .m_wready(m_wready), .m_w_pld(o_m_w_pld[0]),
        .m_bvalid(m_bvalid), .m_bready(o_m_bready[0]), .m_b_pld(m_b_pld),
        .m_acvalid(m_acvalid), .m_acready(o_m_acready[0]), .m_ac_pld(m_ac_pld),
        .m_crvalid(o_m_crvalid[0]), .m_crready(m_crready), .m_cr_pld(o_m_cr_pld[0]),
        .m_cdvalid(o_m_cdvalid[0]), .m_cdready(m_cdready), .m_cd_pld(o_m_cd_pld[0]),
        .arb_err(o_arb_err[0])
    );

    ace_rd_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(2), .ADDR_W(AW), .ID_W(IW), .DATA_W(DW),
        .AW_PLD_W(PW), .W_PLD_W(PW), .B_PLD_W(PW), .AC_PLD_W(PW), .CR_PLD_W(PW), .CD_PLD_W(PW)) u_dut1 (
        .clk(clk), .rst(rst),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(o_ifu_arready[1]), .ifu_araddr(ifu_araddr), .ifu_arid(ifu_arid),
        .ifu_arlen(ifu_arlen), .ifu_arsize(3'd1), .ifu_arburst(2'b01), .ifu_arsnoop(4'd0), .ifu_ardomain(2'd0),
        .ifu_rvalid(o_ifu_rvalid[1]), .ifu_rready(ifu_rready), .ifu_rdata(o_ifu_rdata[1]), .ifu_rid(o_ifu_rid[1]),
        .ifu_rresp(o_ifu_rresp[1]), .ifu_rlast(o_ifu_rlast[1]),
        .ifu_awvalid(1'b0), .ifu_awready(o_ifu_awready[1]), .ifu_wvalid(1'b0), .ifu_wready(o_ifu_wready[1]),
        .ifu_bvalid(o_ifu_bvalid[1]), .ifu_bready(1'b0), .ifu_acvalid(o_ifu_acvalid[1]), .ifu_acready(1'b0),
        .ifu_crvalid(1'b0), .ifu_crready(o_ifu_crready[1]), .ifu_cdvalid(1'b0), .ifu_cdready(o_ifu_cdready[1]),
        .lsu_arvalid(lsu_arvalid), .lsu_arready(o_lsu_arready[1]), .lsu_araddr(lsu_araddr), .lsu_arid(lsu_arid),
        .lsu_arlen(lsu_arlen), .lsu_arsize(3'd1), .lsu_arburst(2'b01), .lsu_arsnoop(4'd0), .lsu_ardomain(2'd1),
        .lsu_rvalid(o_lsu_rvalid[1]), .lsu_rready(lsu_rready), .lsu_rdata(o_lsu_rdata[1]), .lsu_rid(o_lsu_rid[1]),
        .lsu_rresp(o_lsu_rresp[1]), .lsu_rlast(o_lsu_rlast[1]),
        .lsu_awvalid(lsu_awvalid), .lsu_awready(o_lsu_awready[1]), .lsu_aw_pld(lsu_aw_pld),
        .lsu_wvalid(lsu_wvalid), .lsu_wready(o_lsu_wready[1]), .lsu_w_pld(lsu_w_pld),
        .lsu_bvalid(o_lsu_bvalid[1]), .lsu_bready(lsu_bready), .lsu_b_pld(o_lsu_b_pld[1]),
        .lsu_acvalid(o_lsu_acvalid[1]), .lsu_acready(lsu_acready), .lsu_ac_pld(o_lsu_ac_pld[1]),
        .lsu_crvalid(lsu_crvalid), .lsu_crready(o_lsu_crready[1]), .lsu_cr_pld(lsu_cr_pld),
        .lsu_cdvalid(lsu_cdvalid), .lsu_cdready(o_lsu_cdready[1]), .lsu_cd_pld(lsu_cd_pld),
        .m_arvalid(o_m_arvalid[1]), .m_arready(m_arready), .m_araddr(o_m_araddr[1]), .m_arid(o_m_arid[1]),
        .m_arlen(o_m_arlen[1]), .m_arsize(o_m_arsize[1]), .m_arburst(o_m_arburst[1]), .m_arsnoop(o_m_arsnoop[1]),
        .m_ardomain(o_m_ardomain[1]), .m_rvalid(m_rvalid), .m_rready(o_m_rready[1]), .m_rdata(m_rdata),
        .m_rid(m_rid), .m_rresp(4'd0), .m_rlast(m_rlast),
        .m_awvalid(o_m_awvalid[1]), .m_awready(m_awready), .m_aw_pld(o_m_aw_pld[1]),
        .m_wvalid(o_m_wvalid[1]), .m_wready(m_wready), .m_w_pld(o_m_w_pld[1]),
        .m_bvalid(m_bvalid), .m_bready(o_m_bready[1]), .m_b_pld(m_b_pld),
        .m_acvalid(m_acvalid), .m_acready(o_m_acready[1]), .m_ac_pld(m_ac_pld),
        .m_crvalid(o_m_crvalid[1]), .m_crready(m_crready), .m_cr_pld(o_m_cr_pld[1]),
        .m_cdvalid(o_m_cdvalid[1]), .m_cdready(m_cdready), .m_cd_pld(o_m_cd_pld[1]),
        .arb_err(o_arb_err[1])
    );

    // One comparison: counts it, and on mismatch counts a failure and reports it
    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Serve one read burst: pop the expected grant, handshake AR, then return nbeats R beats
    task automatic apply_stimulus(input int nbeats, input bit toggle_rready);
        logic [IW-1:0] exp_id;
        logic          own_lsu;
        logic          rdy;
        int            waited;
        int            beat;
        int            cyc;
        m_arready = 1'b1;
        waited = 0;
        #1;
        while (!s_m_arvalid && waited < 20) begin
            tick();
            waited++;
        end
        if (!s_m_arvalid) begin
            failures++;
            $display("[TB] FAIL ar_timeout observed=0 expected=1");
            return;
        end
        if (exp_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL sb_underflow observed=empty expected=entry");
            return;
        end
        exp_id  = exp_q.pop_front();
        own_lsu = (exp_id == LSU_ID);
        check_output("grant_id", s_m_arid, exp_id);
        check_output("grant_addr", s_m_araddr, own_lsu ? LSU_ADDR : IFU_ADDR);
        check_output("grant_len", s_m_arlen, nbeats - 1);
        check_output("owner_arready", own_lsu ? s_lsu_arready : s_ifu_arready, 1'b1);
        check_output("other_arready", own_lsu ? s_ifu_arready : s_lsu_arready, 1'b0);
        tick();
        beat = 0;
        cyc  = 0;
        while (beat < nbeats && cyc < 40) begin
            rdy = toggle_rready ? cyc[0] : 1'b1;
            if (own_lsu) lsu_rready = rdy; else ifu_rready = rdy;
            m_rvalid = 1'b1;
            m_rdata  = {exp_id, 4'h0, 8'(beat)};
            m_rid    = exp_id;
            m_rlast  = (beat == nbeats - 1);
            #1;
            check_output("owner_rvalid", own_lsu ? s_lsu_rvalid : s_ifu_rvalid, 1'b1);
            check_output("other_rvalid", own_lsu ? s_ifu_rvalid : s_lsu_rvalid, 1'b0);
            check_output("owner_rdata", own_lsu ? s_lsu_rdata : s_ifu_rdata, {exp_id, 4'h0, 8'(beat)});
            check_output("m_rready", s_m_rready, rdy);
            if (s_m_rready) beat++;
            tick();
            cyc++;
        end
        m_rvalid   = 1'b0;
        m_rlast    = 1'b0;
        ifu_rready = 1'b1;
        lsu_rready = 1'b1;
        check_output("beat_count", beat, nbeats);
        #1;
        check_output("idle_after_rlast", s_m_rready, 1'b0);
    endtask

    initial begin
        ifu_arvalid = 1'b1;  lsu_arvalid = 1'b1;
        ifu_rready  = 1'b1;  lsu_rready  = 1'b1;
        ifu_araddr  = IFU_ADDR; ifu_arid = IFU_ID; ifu_arlen = 8'd3;
        lsu_araddr  = LSU_ADDR; lsu_arid = LSU_ID; lsu_arlen = 8'd3;
        m_arready = 1'b1; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rid = '0;
        lsu_awvalid = 1'b0; lsu_wvalid = 1'b0; lsu_bready = 1'b0; lsu_acready = 1'b0;
        lsu_crvalid = 1'b0; lsu_cdvalid = 1'b0;
        lsu_aw_pld = '0; lsu_w_pld = '0; lsu_cr_pld = '0; lsu_cd_pld = '0; m_b_pld = '0; m_ac_pld = '0;
        m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_acvalid = 1'b0; m_crready = 1'b0; m_cdready = 1'b0;
        dut_sel = 1'b0;

        // Reset held with both requesters active
        repeat (3) tick();
        check_output("rst_ifu_arready", s_ifu_arready, 1'b0);
        check_output("rst_lsu_arready", s_lsu_arready, 1'b0);
        check_output("rst_ifu_rvalid", s_ifu_rvalid, 1'b0);
        check_output("rst_lsu_rvalid", s_lsu_rvalid, 1'b0);
        check_output("rst_m_arvalid", s_m_arvalid, 1'b0);
        check_output("rst_m_rready", s_m_rready, 1'b0);
        check_output("rst_arb_err", s_arb_err, 1'b0);
        rst = 1'b1;
        #1;
        check_output("arvalid_before_grant", s_m_arvalid, 1'b0);
        tick();
        check_output("arvalid_one_cycle", s_m_arvalid, 1'b1);
        check_output("first_grant_ifu", s_m_arid, IFU_ID);

        // Round-robin over four 4-beat bursts
        exp_q.push_back(IFU_ID); exp_q.push_back(LSU_ID);
        exp_q.push_back(IFU_ID); exp_q.push_back(LSU_ID);
        for (int i = 0; i < 4; i++) apply_stimulus(4, 1'b0);

        // LSU write/snoop pass-through and IFU tie-offs
        lsu_awvalid = 1'b1; lsu_aw_pld = 8'hA5; m_bvalid = 1'b1; m_b_pld = 8'h3C;
        m_acvalid = 1'b1; m_ac_pld = 8'h5A; lsu_cdvalid = 1'b1; lsu_cd_pld = 8'hC3;
        #1;
        check_output("aw_valid_pass", o_m_awvalid[0], 1'b1);
        check_output("aw_pld_pass", o_m_aw_pld[0], 8'hA5);
        check_output("b_pld_pass", o_lsu_b_pld[0], 8'h3C);
        check_output("ac_pld_pass", o_lsu_ac_pld[0], 8'h5A);
        check_output("cd_pld_pass", o_m_cd_pld[0], 8'hC3);
        check_output("ifu_bvalid_tied", o_ifu_bvalid[0], 1'b0);
        check_output("ifu_acvalid_tied", o_ifu_acvalid[0], 1'b0);
        lsu_awvalid = 1'b0; m_bvalid = 1'b0; m_acvalid = 1'b0; lsu_cdvalid = 1'b0;

        // AR stalled for five cycles, then R with owner rready toggling
        m_arready = 1'b0;
        exp_q.push_back(IFU_ID);
        tick();
        for (int i = 0; i < 5; i++) begin
            check_output("stall_arvalid", s_m_arvalid, 1'b1);
            check_output("stall_araddr", s_m_araddr, IFU_ADDR);
            check_output("stall_arready", s_ifu_arready, 1'b0);
            tick();
        end
        apply_stimulus(4, 1'b1);
        ifu_arvalid = 1'b0;
        lsu_arvalid = 1'b0;

        // Stray read data with no owned burst
        m_rvalid = 1'b1;
        #1;
        check_output("stray_m_rready", s_m_rready, 1'b0);
        check_output("stray_err_pre", s_arb_err, 1'b0);
        tick();
        m_rvalid = 1'b0;
        check_output("stray_err_set", s_arb_err, 1'b1);
        repeat (3) tick();
        check_output("stray_err_sticky", s_arb_err, 1'b1);
        ifu_arvalid = 1'b1;
        ifu_arlen   = 8'd1;
        exp_q.push_back(IFU_ID);
        apply_stimulus(2, 1'b0);
        check_output("err_after_burst", s_arb_err, 1'b1);

        // Asynchronous reset on beat 2 of a 4-beat IFU burst
        ifu_arlen = 8'd3;
        tick();
        check_output("rstmid_arvalid", s_m_arvalid, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            m_rvalid = 1'b1; m_rdata = 16'(i); m_rlast = 1'b0;
            #1;
            check_output("rstmid_beat", s_ifu_rvalid, 1'b1);
            tick();
        end
        m_rvalid = 1'b1;
        #1;
        check_output("rstmid_beat2", s_ifu_rvalid, 1'b1);
        rst = 1'b0;
        #1;
        check_output("rstmid_rvalid", s_ifu_rvalid, 1'b0);
        check_output("rstmid_m_rready", s_m_rready, 1'b0);
        check_output("rstmid_arb_err", s_arb_err, 1'b0);
        m_rvalid = 1'b0;
        tick();
        rst = 1'b1;
        exp_q.push_back(IFU_ID);
        apply_stimulus(4, 1'b0);

        // LSU priority with starvation limit of 2
        ifu_arvalid = 1'b0;
        rst = 1'b0;
        tick();
        dut_sel = 1'b1;
        ifu_arlen = 8'd0; lsu_arlen = 8'd0;
        ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
        exp_q.push_back(LSU_ID); exp_q.push_back(LSU_ID); exp_q.push_back(IFU_ID);
        exp_q.push_back(LSU_ID); exp_q.push_back(LSU_ID); exp_q.push_back(IFU_ID);
        #1;
        check_output("m1_rst_arb_err", s_arb_err, 1'b0);
        rst = 1'b1;
        for (int i = 0; i < 6; i++) apply_stimulus(1, 1'b0);

        check_output("sb_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
